// File: rtl/fetch_unit_redirect_pkg.sv
// Shared definitions for the fetch stage and the instruction-memory harness,
// so both agree on the reset fetch address and the tracker entry layout.
package fetch_unit_redirect_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;
   localparam logic [31:0] INST_BYTES       = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
   } tracker_entry_t;

   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + INST_BYTES;
   endfunction

endpackage

// File: rtl/fetch_unit_redirect_if.sv
// Fetch-to-decode bundle and squash-notification bundle used by the fetch stage.
interface F__DIntf #(parameter int p_seq_num_bits = 5);
   logic                      val;
   logic                      rdy;
   logic [31:0]               inst;
   logic [31:0]               pc;
   logic [p_seq_num_bits-1:0] seq_num;

   modport F_intf (output val, inst, pc, seq_num, input rdy);
   modport D_intf (input val, inst, pc, seq_num, output rdy);
endinterface

interface SquashNotif #(parameter int p_seq_num_bits = 5);
   logic                      val;
   logic [31:0]               target;
   logic [p_seq_num_bits-1:0] seq_num;

   modport pub (output val, target, seq_num);
   modport sub (input val, target, seq_num);
endinterface

// File: rtl/fetch_unit_redirect_tracker_fifo.sv
// In-order FIFO of outstanding request PCs; the head is the PC of the next
// response to come back from memory.
module fetch_tracker_fifo
   import fetch_unit_redirect_pkg::*;
#(
   parameter  int p_depth = 4,
   localparam int PtrW    = $clog2(p_depth),
   localparam int OccW    = $clog2(p_depth) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  tracker_entry_t push_entry,
   input  logic           pop,
   output tracker_entry_t head_entry,
   output logic [OccW-1:0] occ
);

   tracker_entry_t  store [p_depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;

   assign head_entry = store[rd_ptr];

   // Depth is a power of two, so pointers wrap naturally at their width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
         occ <= occ + OccW'(push) - OccW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/fetch_unit_redirect.sv
// In-order fetch stage: sequential PC requests, in-flight tracking, and
// squash redirect that drains every stale response before delivering again.
module fetch_unit_redirect
   import fetch_unit_redirect_pkg::*;
#(
   parameter int          p_seq_num_bits  = 5,
   parameter int          p_max_in_flight = 4,
   parameter logic [31:0] p_reset_pc      = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_val,
   input  logic        mem_req_rdy,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_val,
   output logic        mem_resp_rdy,
   input  logic [31:0] mem_resp_data,
   F__DIntf.F_intf     F,
   SquashNotif.sub     squash_sub
);

   localparam int OccW = $clog2(p_max_in_flight) + 1;
   localparam int SeqW = p_seq_num_bits;

   logic [31:0]     pc_reg;
   logic [31:0]     pc_next;
   logic [SeqW-1:0] seq_reg;
   logic [SeqW-1:0] seq_next;
   logic [OccW-1:0] drop_cnt;
   logic [OccW-1:0] drop_cnt_next;
   logic [OccW-1:0] occ;
   logic [OccW-1:0] occ_next;
   logic            req_fire;
   logic            resp_fire;
   logic            dropping;
   logic            occ_full;
   tracker_entry_t  push_entry;
   tracker_entry_t  head_entry;

   assign push_entry.pc = pc_reg;

   fetch_tracker_fifo #(.p_depth(p_max_in_flight)) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .push       (req_fire),
      .push_entry (push_entry),
      .pop        (resp_fire),
      .head_entry (head_entry),
      .occ        (occ)
   );

   // A full tracker may still issue when a response retires in the same cycle.
   always_comb begin
      occ_full     = (occ == OccW'(p_max_in_flight));
      dropping     = (drop_cnt != '0) | squash_sub.val;
      mem_resp_rdy = rst & (dropping | F.rdy);
      resp_fire    = mem_resp_val & mem_resp_rdy;
      mem_req_val  = rst & ~(occ_full & ~resp_fire);
      mem_req_addr = pc_reg;
      req_fire     = mem_req_val & mem_req_rdy;
      occ_next     = occ + OccW'(req_fire) - OccW'(resp_fire);

      F.val     = rst & mem_resp_val & ~dropping;
      F.inst    = mem_resp_data;
      F.pc      = head_entry.pc;
      F.seq_num = seq_reg;
   end

   // Squash takes priority: everything still in flight, including a request
   // issued this very cycle, belongs to the squashed path.
   always_comb begin
      pc_next       = pc_reg;
      seq_next      = seq_reg;
      drop_cnt_next = drop_cnt;
      if (squash_sub.val) begin
         pc_next       = squash_sub.target;
         seq_next      = squash_sub.seq_num + SeqW'(1);
         drop_cnt_next = occ_next;
      end else begin
         if (req_fire)             pc_next  = next_seq_pc(pc_reg);
         if (F.val & F.rdy)        seq_next = seq_reg + SeqW'(1);
         if (resp_fire & (drop_cnt != '0))
            drop_cnt_next = drop_cnt - OccW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg   <= p_reset_pc;
         seq_reg  <= '0;
         drop_cnt <= '0;
      end else begin
         pc_reg   <= pc_next;
         seq_reg  <= seq_next;
         drop_cnt <= drop_cnt_next;
      end
   end

endmodule
